// File: rtl/fp_pkg.sv
// Shared floating-point constants and helpers for the fp_* task schedulers.
package fp_pkg;

    localparam logic [31:0] FP_HALF   = 32'h3f000000;
    localparam logic [31:0] FP_M128   = 32'hc3000000;
    localparam logic [31:0] FP_DIV128 = 32'h3c000000;

    localparam int MAX_REQ = 8;

    // Width of a requester tag; never narrower than one bit.
    function automatic int tag_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Widest tag any scheduler instance needs.
    typedef logic [$clog2(MAX_REQ)-1:0] tag_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester-side bus of the shared multiplier: request operands in, tagged result strobes out.
interface fp_mult_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_any
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             grant_ok;
    int               idx;

    // Scan ptr+1, ptr+2, ... (mod N_REQ) and keep the first active request.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    // No grant while held in reset or while the pipeline is stalled.
    assign grant_ok = en & ~reset & found;

    // Expand the winner index to a one-hot grant.
    always_comb begin
        gnt = '0;
        if (grant_ok) begin
            gnt[win] = 1'b1;
        end
    end

    // Remember the last winner; reset value gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PTR_W'(N_REQ - 1);
        end else if (grant_ok) begin
            ptr <= win;
        end
    end

    assign gnt_idx = win;
    assign gnt_any = grant_ok;

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined fp_mult between N_REQ requesters and routes each product
// back to its originator after the fixed multiplier latency.
module fp_mult_arbiter
    import fp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3,
    parameter int DATA_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    fp_mult_arbiter_if.slave    req_bus,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic [DATA_W-1:0]   mul_q
);
    localparam int TAG_W = tag_width(N_REQ);

    logic [N_REQ-1:0]  gnt;
    logic [TAG_W-1:0]  win;
    logic              transfer;

    // In-flight tracker mirrors the multiplier pipeline, one entry per stage.
    logic [MUL_LAT-1:0] trk_vld;
    logic [TAG_W-1:0]   trk_tag [MUL_LAT];

    logic [N_REQ-1:0]  rsp_vld_q;
    logic [DATA_W-1:0] rsp_data_q;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (clk_en),
        .req     (req_bus.req_valid),
        .gnt     (gnt),
        .gnt_idx (win),
        .gnt_any (transfer)
    );

    assign req_bus.req_ready = gnt;

    // Steer the granted requester's operands to the multiplier; zero when idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mul_a = req_bus.req_a[i*DATA_W +: DATA_W];
                mul_b = req_bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Shift issued tags alongside the multiplier; frozen whenever clk_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                trk_tag[i] <= '0;
            end
        end else if (clk_en) begin
            trk_vld[0] <= transfer;
            trk_tag[0] <= win;
            for (int i = 1; i < MUL_LAT; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_tag[i] <= trk_tag[i-1];
            end
        end
    end

    // Retire the oldest entry: one-cycle strobe to its owner, product held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= '0;
            if (clk_en && trk_vld[MUL_LAT-1]) begin
                rsp_vld_q[trk_tag[MUL_LAT-1]] <= 1'b1;
                rsp_data_q                    <= mul_q;
            end
        end
    end

    assign req_bus.rsp_valid = rsp_vld_q;
    assign req_bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a 3-stage behavioural fp_mult.
module tb_fp_mult_arbiter;
    import fp_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int W   = 32;

    localparam logic [127:0] A_ALL = {4{32'h3f800000}};
    localparam logic [127:0] B_ALL = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};
    localparam logic [127:0] A_ONE = {32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40000000};
    localparam logic [127:0] B_ONE = {32'h40800000, 32'h40400000, 32'h40000000, 32'h40400000};

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_en;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_q;
    logic [W-1:0] pipe [LAT];

    int n_checks = 0;
    int n_fail   = 0;

    fp_mult_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    fp_mult_arbiter #(.N_REQ(N), .MUL_LAT(LAT), .DATA_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .req_bus (bus),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_q   (mul_q)
    );

    always #5 clk = ~clk;

    // Truncating single-precision multiply, exact for the small operands used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {s, 8'(e + 1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (clk_en) begin
            pipe[0] <= fmul(mul_a, mul_b);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_q = pipe[LAT-1];

    typedef struct {
        logic [3:0]   rv;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   ready;
        logic [31:0]  ma;
        logic [31:0]  mb;
        logic [3:0]   rsp;
        logic [31:0]  data;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic [3:0] rv, input logic [127:0] a, input logic [127:0] b,
                        input logic [3:0] ready, input logic [31:0] ma, input logic [31:0] mb,
                        input logic [3:0] rsp, input logic [31:0] data);
        vec_t v;
        v.rv = rv; v.a = a; v.b = b; v.ready = ready;
        v.ma = ma; v.mb = mb; v.rsp = rsp; v.data = data;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Full contention from reset: grants 0,1,2,3,0 then back-to-back responses.
        addv(4'b1111, A_ALL, B_ALL, 4'b0001, 32'h3f800000, 32'h3f800000, 4'b0000, 32'h0);
        addv(4'b1111, A_ALL, B_ALL, 4'b0010, 32'h3f800000, 32'h40000000, 4'b0000, 32'h0);
        addv(4'b1111, A_ALL, B_ALL, 4'b0100, 32'h3f800000, 32'h40400000, 4'b0000, 32'h0);
        addv(4'b1111, A_ALL, B_ALL, 4'b1000, 32'h3f800000, 32'h40800000, 4'b0000, 32'h0);
        addv(4'b1111, A_ALL, B_ALL, 4'b0001, 32'h3f800000, 32'h3f800000, 4'b0001, 32'h3f800000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0010, 32'h40000000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0100, 32'h40400000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b1000, 32'h40800000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0001, 32'h3f800000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h3f800000);
        // Single request 2.0 * 3.0, response four cycles later.
        addv(4'b0001, A_ONE, B_ONE, 4'b0001, 32'h40000000, 32'h40400000, 4'b0000, 32'h3f800000);
        addv(4'b0000, A_ONE, B_ONE, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h3f800000);
        addv(4'b0000, A_ONE, B_ONE, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h3f800000);
        addv(4'b0000, A_ONE, B_ONE, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h3f800000);
        addv(4'b0000, A_ONE, B_ONE, 4'b0000, 32'h0, 32'h0, 4'b0001, 32'h40c00000);
        addv(4'b0000, A_ONE, B_ONE, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h40c00000);
        // Pointer rotation: after a grant to 2, requesters 1 and 3 -> 3 first, then 1.
        addv(4'b0100, A_ALL, B_ALL, 4'b0100, 32'h3f800000, 32'h40400000, 4'b0000, 32'h40c00000);
        addv(4'b1010, A_ALL, B_ALL, 4'b1000, 32'h3f800000, 32'h40800000, 4'b0000, 32'h40c00000);
        addv(4'b0010, A_ALL, B_ALL, 4'b0010, 32'h3f800000, 32'h40000000, 4'b0000, 32'h40c00000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h40c00000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0100, 32'h40400000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b1000, 32'h40800000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0010, 32'h40000000);
        addv(4'b0000, A_ALL, B_ALL, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h40000000);

        // Reset: grants and operands forced to zero even with every request active.
        reset = 1'b1;
        clk_en = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a = A_ALL;
        bus.req_b = B_ALL;
        #1;
        @(negedge clk);
        check("reset ready", 32'(bus.req_ready), 32'h0);
        check("reset mul_a", mul_a, 32'h0);
        check("reset mul_b", mul_b, 32'h0);
        next_cycle();
        @(negedge clk);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset rsp_data", bus.rsp_data, 32'h0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            bus.req_valid = vq[i].rv;
            bus.req_a = vq[i].a;
            bus.req_b = vq[i].b;
            @(negedge clk);
            check($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(vq[i].ready));
            check($sformatf("v%0d mul_a", i), mul_a, vq[i].ma);
            check($sformatf("v%0d mul_b", i), mul_b, vq[i].mb);
            check($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vq[i].rsp));
            check($sformatf("v%0d rsp_data", i), bus.rsp_data, vq[i].data);
            next_cycle();
        end

        // Enable stall: issue to requester 2, freeze for 5 cycles, then 3 enabled cycles.
        bus.req_a = A_ALL;
        bus.req_b = B_ALL;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("stall issue ready", 32'(bus.req_ready), 32'b0100);
        next_cycle();
        clk_en = 1'b0;
        bus.req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d ready", i), 32'(bus.req_ready), 32'h0);
            check($sformatf("stall%0d rsp_valid", i), 32'(bus.rsp_valid), 32'h0);
            next_cycle();
        end
        clk_en = 1'b1;
        bus.req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("resume%0d rsp_valid", i), 32'(bus.rsp_valid), 32'h0);
            next_cycle();
        end
        @(negedge clk);
        check("stall rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        check("stall rsp_data", bus.rsp_data, 32'h40400000);
        next_cycle();
        @(negedge clk);
        check("stall rsp one-shot", 32'(bus.rsp_valid), 32'h0);
        next_cycle();

        // Reset mid-flight: three ops issued (pointer at 2 -> grants 3,0,1), then reset.
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("mid issue0", 32'(bus.req_ready), 32'b1000);
        next_cycle();
        @(negedge clk);
        check("mid issue1", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        @(negedge clk);
        check("mid issue2", 32'(bus.req_ready), 32'b0010);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("mid reset ready", 32'(bus.req_ready), 32'h0);
        next_cycle();
        reset = 1'b0;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("mid rsp_data cleared", bus.rsp_data, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mid drain%0d rsp_valid", i), 32'(bus.rsp_valid), 32'h0);
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("post reset grant", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        bus.req_valid = 4'b0000;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
